id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection for the five-stage MIPS pipeline. It sits directly downstream of the main control decoder and register file. It captures the decoded control bits and operands at the clock edge and hands them to the EX stage. It inserts a bubble (all control zeroed) on a load-use hazard or an external flush, drives the PC/IF-ID hold signals, and keeps saturating stall and flush event counters for debug.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush event counters

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- ctrl_branch, ctrl_bne, ctrl_mem_read, ctrl_mem_to_reg, ctrl_mem_write, ctrl_alu_src, ctrl_reg_write, ctrl_reg_dst  in  1 each  decoded control from the main control decoder. ctrl_mem_to_reg=1 selects the ALU result; 0 selects memory data.
- ctrl_alu_op  in  2  ALU op class (00 add, 01 sub/compare, 10 R-type funct, 11 and)
- id_pc_plus4, id_read_data1, id_read_data2, id_imm_ext  in  32 each  ID-stage data
- id_rs, id_rt, id_rd  in  5 each  register specifiers of the instruction in ID
- id_funct  in  6  funct field of the instruction in ID
- flush  in  1  kill the instruction entering EX (branch/jump redirect)
- ex_branch, ex_bne, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write, ex_reg_dst  out  1 each  registered control
- ex_alu_op  out  2  registered ALU op
- ex_pc_plus4, ex_read_data1, ex_read_data2, ex_imm_ext  out  32 each  registered data
- ex_rs, ex_rt, ex_rd  out  5 each; ex_funct  out  6  registered fields
- stall  out  1  combinational load-use hazard indication
- pc_write, if_id_write  out  1 each  combinational; both equal ~stall
- stall_count, flush_count  out  CNT_W each  saturating event counters

## Operation
- Hazard detect (combinational): hazard = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)). The check is conservative: rt is compared for every opcode.
- stall = hazard & ~flush. A flushed ID instruction never stalls.
- Register update priority per edge: reset > flush > stall > normal load.
  - reset: every ex_* output goes to 0 (control and data); both counters go to 0.
  - flush: all 9 control outputs (8 single-bit plus ex_alu_op) go to 0 (bubble). Data and field registers load from the ID inputs normally.
  - stall: the same bubble is inserted. Data and field registers load normally. The instruction in ID is held upstream via pc_write = if_id_write = 0.
  - normal: every ex_* output loads its corresponding ID input unmodified.
- A bubble is defined as ex_reg_write = ex_mem_write = ex_mem_read = ex_branch = ex_bne = 0. It has no architectural effect downstream.
- Counters:
  - stall_count increments on each edge where stall = 1.
  - flush_count increments on each edge where flush = 1.
  - Both saturate at 2^CNT_W−1 and never wrap.
  - The reset clause takes priority over any increment.

## Timing
- ID inputs sampled at edge N appear on the ex_* outputs after edge N. Latency is 1 cycle.
- stall, pc_write and if_id_write are purely combinational from the current ex_mem_read/ex_rt and id_rs/id_rt/flush. There is no registered delay.
- A load-use hazard causes exactly one stall cycle:
  - Edge N: bubble enters EX; the lw moves to MEM.
  - Edge N+1: ex_mem_read is now 0, so stall drops and the held instruction enters EX.
- If reset is asserted while a stall is pending, reset wins. After the reset edge, ex_mem_read = 0, so stall = 0 and pc_write = 1.
- If flush and hazard are asserted in the same cycle: stall = 0, pc_write = 1, a bubble is inserted, and only flush_count increments.
- reset = 1 with flush = 1: counters read 0 after the edge; no increment occurs.

## Test plan
- Reset: drive random ID inputs with reset = 1 for 2 edges. Every ex_* output, stall_count and flush_count must read 0, and pc_write must read 1.
- Pass-through of lw: ctrl_mem_read = 1, ctrl_alu_src = 1, ctrl_reg_write = 1, ctrl_alu_op = 00, id_rt = 8, id_imm_ext = 0x4. After one edge, the ex_* outputs must show the same values and stall must read 0.
- Load-use: lw with rt = 8 in EX and id_rs = 8 in ID.
  - Before the edge: stall = 1 and pc_write = 0.
  - After the edge: the bubble has all ex_* control = 0 and stall_count = 1.
  - The next cycle: stall = 0, and the held add loads with ex_reg_dst = 1 and ex_alu_op = 10.
- Zero register: lw with rt = 0 in EX and id_rs = 0 in ID. stall must stay 0 and the instruction must load normally.
- Flush with hazard: the load-use condition from the previous scenario plus flush = 1. stall must read 0 and pc_write 1. After the edge: control is bubbled, flush_count = 1, stall_count is unchanged.
- Saturation: with CNT_W = 4, hold the hazard condition for 20 edges with ex_mem_read forced. stall_count must stop at 15.

Source files
------------

// File: rtl/id_ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : id_ex_stage                                                   |
// | Purpose  : ID/EX pipeline register with load-use hazard detection,       |
// |            bubble insertion and saturating stall/flush event counters.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module id_ex_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctrl_branch,
  input  logic             ctrl_bne,
  input  logic             ctrl_mem_read,
  input  logic             ctrl_mem_to_reg,
  input  logic             ctrl_mem_write,
  input  logic             ctrl_alu_src,
  input  logic             ctrl_reg_write,
  input  logic             ctrl_reg_dst,
  input  logic [1:0]       ctrl_alu_op,
  input  logic [31:0]      id_pc_plus4,
  input  logic [31:0]      id_read_data1,
  input  logic [31:0]      id_read_data2,
  input  logic [31:0]      id_imm_ext,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic [5:0]       id_funct,
  input  logic             flush,
  output logic             ex_branch,
  output logic             ex_bne,
  output logic             ex_mem_read,
  output logic             ex_mem_to_reg,
  output logic             ex_mem_write,
  output logic             ex_alu_src,
  output logic             ex_reg_write,
  output logic             ex_reg_dst,
  output logic [1:0]       ex_alu_op,
  output logic [31:0]      ex_pc_plus4,
  output logic [31:0]      ex_read_data1,
  output logic [31:0]      ex_read_data2,
  output logic [31:0]      ex_imm_ext,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_rd,
  output logic [5:0]       ex_funct,
  output logic             stall,
  output logic             pc_write,
  output logic             if_id_write,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  logic             w_hazard;
  logic [9:0]       w_ctrl_in;
  logic [9:0]       ctrl_d, ctrl_q;
  logic [31:0]      pc4_d, pc4_q, rd1_d, rd1_q, rd2_d, rd2_q, imm_d, imm_q;
  logic [4:0]       rs_d, rs_q, rt_d, rt_q, rd_d, rd_q;
  logic [5:0]       funct_d, funct_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;

  // rt is compared for every opcode; false stalls are harmless, missed ones are not
  assign w_hazard    = ex_mem_read && (ex_rt != 5'd0) &&
                       ((ex_rt == id_rs) || (ex_rt == id_rt));
  assign stall       = w_hazard && !flush;
  assign pc_write    = !stall;
  assign if_id_write = !stall;

  assign w_ctrl_in = {ctrl_branch, ctrl_bne, ctrl_mem_read, ctrl_mem_to_reg,
                      ctrl_mem_write, ctrl_alu_src, ctrl_reg_write, ctrl_reg_dst,
                      ctrl_alu_op};

  always_comb begin
    ctrl_d      = (flush || stall) ? 10'd0 : w_ctrl_in;
    pc4_d       = id_pc_plus4;
    rd1_d       = id_read_data1;
    rd2_d       = id_read_data2;
    imm_d       = id_imm_ext;
    rs_d        = id_rs;
    rt_d        = id_rt;
    rd_d        = id_rd;
    funct_d     = id_funct;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != C_CNT_MAX)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush && (flush_cnt_q != C_CNT_MAX)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q      <= '0;
      pc4_q       <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      funct_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      pc4_q       <= pc4_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      imm_q       <= imm_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      funct_q     <= funct_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign {ex_branch, ex_bne, ex_mem_read, ex_mem_to_reg, ex_mem_write,
          ex_alu_src, ex_reg_write, ex_reg_dst, ex_alu_op} = ctrl_q;
  assign ex_pc_plus4   = pc4_q;
  assign ex_read_data1 = rd1_q;
  assign ex_read_data2 = rd2_q;
  assign ex_imm_ext    = imm_q;
  assign ex_rs         = rs_q;
  assign ex_rt         = rt_q;
  assign ex_rd         = rd_q;
  assign ex_funct      = funct_q;
  assign stall_count   = stall_cnt_q;
  assign flush_count   = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_id_ex_stage                                                |
// | Purpose  : Directed self-checking bench for id_ex_stage.                 |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_id_ex_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush;
  logic        c_br, c_bne, c_mr, c_m2r, c_mw, c_as, c_rw, c_rd;
  logic [1:0]  c_op;
  logic [31:0] pc4, rd1, rd2, imm;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;

  logic        e_br, e_bne, e_mr, e_m2r, e_mw, e_as, e_rw, e_rd;
  logic [1:0]  e_op;
  logic [31:0] e_pc4, e_rd1, e_rd2, e_imm;
  logic [4:0]  e_rs, e_rt, e_rdr;
  logic [5:0]  e_funct;
  logic        stall, pc_write, if_id_write;
  logic [15:0] stall_count, flush_count;

  logic        s_br, s_bne, s_mr, s_m2r, s_mw, s_as, s_rw, s_rd;
  logic [1:0]  s_op;
  logic [31:0] s_pc4, s_rd1, s_rd2, s_imm;
  logic [4:0]  s_rs, s_rt, s_rdr;
  logic [5:0]  s_funct;
  logic        s_stall, s_pc_write, s_if_id_write;
  logic [3:0]  s_stall_count, s_flush_count;

  id_ex_stage #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .ctrl_branch(c_br), .ctrl_bne(c_bne), .ctrl_mem_read(c_mr), .ctrl_mem_to_reg(c_m2r),
    .ctrl_mem_write(c_mw), .ctrl_alu_src(c_as), .ctrl_reg_write(c_rw), .ctrl_reg_dst(c_rd),
    .ctrl_alu_op(c_op), .id_pc_plus4(pc4), .id_read_data1(rd1), .id_read_data2(rd2),
    .id_imm_ext(imm), .id_rs(rs), .id_rt(rt), .id_rd(rd), .id_funct(funct), .flush(flush),
    .ex_branch(e_br), .ex_bne(e_bne), .ex_mem_read(e_mr), .ex_mem_to_reg(e_m2r),
    .ex_mem_write(e_mw), .ex_alu_src(e_as), .ex_reg_write(e_rw), .ex_reg_dst(e_rd),
    .ex_alu_op(e_op), .ex_pc_plus4(e_pc4), .ex_read_data1(e_rd1), .ex_read_data2(e_rd2),
    .ex_imm_ext(e_imm), .ex_rs(e_rs), .ex_rt(e_rt), .ex_rd(e_rdr), .ex_funct(e_funct),
    .stall(stall), .pc_write(pc_write), .if_id_write(if_id_write),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  id_ex_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .ctrl_branch(c_br), .ctrl_bne(c_bne), .ctrl_mem_read(c_mr), .ctrl_mem_to_reg(c_m2r),
    .ctrl_mem_write(c_mw), .ctrl_alu_src(c_as), .ctrl_reg_write(c_rw), .ctrl_reg_dst(c_rd),
    .ctrl_alu_op(c_op), .id_pc_plus4(pc4), .id_read_data1(rd1), .id_read_data2(rd2),
    .id_imm_ext(imm), .id_rs(rs), .id_rt(rt), .id_rd(rd), .id_funct(funct), .flush(flush),
    .ex_branch(s_br), .ex_bne(s_bne), .ex_mem_read(s_mr), .ex_mem_to_reg(s_m2r),
    .ex_mem_write(s_mw), .ex_alu_src(s_as), .ex_reg_write(s_rw), .ex_reg_dst(s_rd),
    .ex_alu_op(s_op), .ex_pc_plus4(s_pc4), .ex_read_data1(s_rd1), .ex_read_data2(s_rd2),
    .ex_imm_ext(s_imm), .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rdr), .ex_funct(s_funct),
    .stall(s_stall), .pc_write(s_pc_write), .if_id_write(s_if_id_write),
    .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  // Control packed as {branch,bne,mem_read,mem_to_reg,mem_write,alu_src,reg_write,reg_dst,alu_op}
  logic [9:0] ex_ctrl;
  assign ex_ctrl = {e_br, e_bne, e_mr, e_m2r, e_mw, e_as, e_rw, e_rd, e_op};

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctrl(input logic [9:0] v);
    {c_br, c_bne, c_mr, c_m2r, c_mw, c_as, c_rw, c_rd, c_op} = v;
  endtask

  // lw: mem_read, alu_src, reg_write, alu_op=00
  localparam logic [9:0] LW_CTRL  = 10'b0010011000;
  // add: mem_to_reg (ALU result), reg_write, reg_dst, alu_op=10
  localparam logic [9:0] ADD_CTRL = 10'b0001001110;

  task automatic set_id(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                        input logic [31:0] im, input logic [5:0] f);
    rs = s; rt = t; rd = d; imm = im; funct = f;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    set_ctrl(10'h3FF);
    pc4 = $urandom; rd1 = $urandom; rd2 = $urandom; imm = $urandom;
    rs = 5'd8; rt = 5'd8; rd = 5'd8; funct = 6'h3F;
    tick();
    tick();
    check("rst_ctrl",   {54'd0, ex_ctrl}, 64'd0);
    check("rst_data",   {e_pc4, e_rd1} | {e_rd2, e_imm}, 64'd0);
    check("rst_fields", {48'd0, e_rs, e_rt, e_rdr, e_funct}, 64'd0);
    check("rst_cnts",   {32'd0, stall_count, flush_count}, 64'd0);
    check("rst_pcw",    {63'd0, pc_write}, 64'd1);

    // lw pass-through
    reset = 1'b0;
    set_ctrl(LW_CTRL);
    pc4 = 32'h100; rd1 = 32'h1000; rd2 = 32'h55;
    set_id(5'd9, 5'd8, 5'd0, 32'h4, 6'h00);
    tick();
    check("lw_ctrl", {54'd0, ex_ctrl}, {54'd0, LW_CTRL});
    check("lw_rt",   {59'd0, e_rt}, 64'd8);
    check("lw_imm",  {32'd0, e_imm}, 64'h4);
    check("lw_data", {e_pc4, e_rd1}, {32'h100, 32'h1000});
    set_id(5'd1, 5'd2, 5'd3, 32'h0, 6'h00);
    #1;
    check("lw_nostall", {63'd0, stall}, 64'd0);

    // Load-use: add with rs = 8 behind lw rt = 8
    set_ctrl(ADD_CTRL);
    set_id(5'd8, 5'd9, 5'd10, 32'h0, 6'h20);
    #1;
    check("lu_stall",  {63'd0, stall}, 64'd1);
    check("lu_pcw",    {62'd0, pc_write, if_id_write}, 64'd0);
    tick();
    check("lu_bubble", {54'd0, ex_ctrl}, 64'd0);
    check("lu_scnt",   {48'd0, stall_count}, 64'd1);
    check("lu_data",   {59'd0, e_rs}, 64'd8);
    check("lu_release",{63'd0, stall}, 64'd0);
    tick();
    check("lu_add_ctrl", {54'd0, ex_ctrl}, {54'd0, ADD_CTRL});
    check("lu_add_flds", {53'd0, e_rdr, e_funct}, {53'd0, 5'd10, 6'h20});

    // Zero register never hazards
    set_ctrl(LW_CTRL);
    set_id(5'd5, 5'd0, 5'd0, 32'h8, 6'h00);
    tick();
    set_ctrl(ADD_CTRL);
    set_id(5'd0, 5'd0, 5'd4, 32'h0, 6'h20);
    #1;
    check("z_nostall", {63'd0, stall}, 64'd0);
    tick();
    check("z_ctrl", {54'd0, ex_ctrl}, {54'd0, ADD_CTRL});
    check("z_scnt", {48'd0, stall_count}, 64'd1);

    // Flush overrides hazard
    set_ctrl(LW_CTRL);
    set_id(5'd3, 5'd8, 5'd0, 32'h4, 6'h00);
    tick();
    set_ctrl(ADD_CTRL);
    set_id(5'd8, 5'd9, 5'd10, 32'h0, 6'h20);
    flush = 1'b1;
    #1;
    check("fl_stall", {63'd0, stall}, 64'd0);
    check("fl_pcw",   {63'd0, pc_write}, 64'd1);
    tick();
    flush = 1'b0;
    check("fl_bubble", {54'd0, ex_ctrl}, 64'd0);
    check("fl_fcnt",   {48'd0, flush_count}, 64'd1);
    check("fl_scnt",   {48'd0, stall_count}, 64'd1);

    // 20 more load-use stalls: 4-bit counter saturates, 16-bit one keeps counting
    for (int i = 0; i < 20; i++) begin
      set_ctrl(LW_CTRL);
      set_id(5'd3, 5'd8, 5'd0, 32'h4, 6'h00);
      tick();
      set_id(5'd8, 5'd3, 5'd0, 32'h4, 6'h00);
      tick();
    end
    check("sat_cnt4",  {60'd0, s_stall_count}, 64'd15);
    check("sat_cnt16", {48'd0, stall_count}, 64'd21);
    check("sat_fcnt4", {60'd0, s_flush_count}, 64'd1);

    // Reset while a stall is pending, with flush also asserted
    set_ctrl(LW_CTRL);
    set_id(5'd3, 5'd8, 5'd0, 32'h4, 6'h00);
    tick();
    set_ctrl(ADD_CTRL);
    set_id(5'd8, 5'd9, 5'd10, 32'h0, 6'h20);
    #1;
    check("rp_stall", {63'd0, stall}, 64'd1);
    reset = 1'b1;
    flush = 1'b1;
    tick();
    reset = 1'b0;
    flush = 1'b0;
    #1;
    check("rp_after_stall", {62'd0, stall, pc_write}, 64'd1);
    check("rp_cnts", {32'd0, stall_count, flush_count}, 64'd0);
    check("rp_ctrl", {54'd0, ex_ctrl}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
